// File: rtl/memory_game_ctrl_if.sv
// Player-facing signal bundle of the memory game controller: the game/timebase/keypad
// inputs and the display/status outputs.
interface memory_game_ctrl_if;
    logic       start;
    logic       tick;
    logic [3:0] rnd;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [3:0] disp_digit;
    logic       disp_on;
    logic [3:0] level;
    logic       busy;
    logic       win;
    logic       lose;

    modport master (
        output start, tick, rnd, key_valid, key_digit,
        input  disp_digit, disp_on, level, busy, win, lose
    );

    modport slave (
        input  start, tick, rnd, key_valid, key_digit,
        output disp_digit, disp_on, level, busy, win, lose
    );
endinterface

// File: rtl/memory_game_ctrl.sv
// Memory game sequencer: grows a random digit sequence one digit per level, plays it
// back on the display and checks the player's key entries against it.
module memory_game_ctrl #(
    parameter int unsigned MAX_LEN       = 8,
    parameter int unsigned SHOW_TICKS    = 4,
    parameter int unsigned GAP_TICKS     = 1,
    parameter int unsigned TIMEOUT_TICKS = 16
) (
    input  logic              clk,
    input  logic              reset,
    memory_game_ctrl_if.slave bus
);
    localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH  = 2 ** IDX_W;
    localparam int unsigned MAX_T0 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned MAX_T  = (MAX_T0 > TIMEOUT_TICKS) ? MAX_T0 : TIMEOUT_TICKS;
    localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [3:0]       LEN_MAX   = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SHOW, S_GAP, S_INPUT, S_WIN, S_LOSE
    } state_t;

    state_t            state;
    logic [3:0]        level;
    logic [IDX_W-1:0]  play_idx;
    logic [IDX_W-1:0]  in_idx;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        digits [DEPTH];

    logic [3:0]        disp_digit;
    logic              disp_on;
    logic              busy;
    logic              win;
    logic              lose;

    logic [3:0]        rnd_adj;
    logic [IDX_W-1:0]  last_idx;
    logic              key_match;

    // Fold 10..15 back into 0..5 so the buffer only ever holds decimal digits.
    assign rnd_adj   = (bus.rnd > 4'd9) ? (bus.rnd - 4'd10) : bus.rnd;
    assign last_idx  = IDX_W'(level - 4'd1);
    assign key_match = (bus.key_digit == digits[in_idx]);

    // Sequence buffer: one new digit appended per level, earlier ones untouched.
    always_ff @(posedge clk) begin
        if (!reset && state == S_GEN) begin
            digits[last_idx] <= rnd_adj;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            level      <= '0;
            play_idx   <= '0;
            in_idx     <= '0;
            cnt        <= '0;
            disp_digit <= '0;
            disp_on    <= 1'b0;
            busy       <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (bus.start) begin
                        state    <= S_GEN;
                        level    <= 4'd1;
                        play_idx <= '0;
                        in_idx   <= '0;
                        cnt      <= '0;
                        disp_on  <= 1'b0;
                        busy     <= 1'b1;
                        win      <= 1'b0;
                        lose     <= 1'b0;
                    end
                end

                // On level 1 the digit being written this cycle is the one shown next.
                S_GEN: begin
                    state      <= S_SHOW;
                    play_idx   <= '0;
                    cnt        <= '0;
                    disp_on    <= 1'b1;
                    disp_digit <= (last_idx == '0) ? rnd_adj : digits[0];
                end

                S_SHOW: begin
                    if (bus.tick) begin
                        if (cnt == SHOW_LAST) begin
                            state   <= S_GAP;
                            cnt     <= '0;
                            disp_on <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                S_GAP: begin
                    if (bus.tick) begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (play_idx == last_idx) begin
                                state  <= S_INPUT;
                                in_idx <= '0;
                            end else begin
                                state      <= S_SHOW;
                                play_idx   <= play_idx + IDX_W'(1);
                                disp_on    <= 1'b1;
                                disp_digit <= digits[play_idx + IDX_W'(1)];
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                // A key press wins over a timeout-completing tick in the same cycle.
                S_INPUT: begin
                    if (bus.key_valid && key_match) begin
                        cnt <= '0;
                        if (in_idx != last_idx) begin
                            in_idx <= in_idx + IDX_W'(1);
                        end else if (level < LEN_MAX) begin
                            level <= level + 4'd1;
                            state <= S_GEN;
                        end else begin
                            state   <= S_WIN;
                            win     <= 1'b1;
                            busy    <= 1'b0;
                            disp_on <= 1'b0;
                        end
                    end else if (bus.key_valid || (bus.tick && cnt == TO_LAST)) begin
                        state      <= S_LOSE;
                        cnt        <= '0;
                        lose       <= 1'b1;
                        busy       <= 1'b0;
                        disp_on    <= 1'b1;
                        disp_digit <= digits[in_idx];
                    end else if (bus.tick) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.disp_digit = disp_digit;
    assign bus.disp_on    = disp_on;
    assign bus.level      = level;
    assign bus.busy       = busy;
    assign bus.win        = win;
    assign bus.lose       = lose;
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: expected playback digits are queued as each
// level is started and popped by a monitor whenever a digit appears on the display.
module tb_memory_game_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    memory_game_ctrl_if bus();

    memory_game_ctrl #(
        .MAX_LEN      (3),
        .SHOW_TICKS   (4),
        .GAP_TICKS    (1),
        .TIMEOUT_TICKS(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q [$];
    logic       prev_on = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        cyc();
    endtask

    task automatic key(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        cyc();
        bus.key_valid = 1'b0;
    endtask

    // Start a game and step through GEN so the first digit is on display.
    task automatic start_game(input logic [3:0] r);
        bus.rnd   = r;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cyc();
    endtask

    // Tick through the whole playback of a level and confirm the player's turn began.
    task automatic play_level(input int len);
        repeat (len * 5) tick_pulse();
        check("input_busy", 8'(bus.busy), 8'd1);
        check("input_blank", 8'(bus.disp_on), 8'd0);
        check("playback_drained", 8'(exp_q.size()), 8'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_digit"}, 8'(bus.disp_digit), 8'd0);
        check({tag, "_on"},    8'(bus.disp_on),    8'd0);
        check({tag, "_level"}, 8'(bus.level),      8'd0);
        check({tag, "_busy"},  8'(bus.busy),       8'd0);
        check({tag, "_win"},   8'(bus.win),        8'd0);
        check({tag, "_lose"},  8'(bus.lose),       8'd0);
    endtask

    // Playback scoreboard: each new digit shown during a game consumes one expectation.
    always @(negedge clk) begin
        if (!reset && bus.busy && bus.disp_on && !prev_on) begin
            check("playback_expected", 8'(exp_q.size() != 0), 8'd1);
            if (exp_q.size() != 0) begin
                check("playback_digit", 8'(bus.disp_digit), 8'(exp_q.pop_front()));
            end
        end
        prev_on <= bus.disp_on;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.tick      = 1'b0;
        bus.rnd       = 4'd0;
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        repeat (3) cyc();
        check_idle("reset");

        // Idle ignores ticks and keys
        reset = 1'b0;
        tick_pulse();
        key(4'd3);
        cyc();
        check_idle("idle");

        // First digit appears two cycles after start
        bus.rnd = 4'd7;
        exp_q.push_back(4'd7);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("gen_busy", 8'(bus.busy), 8'd1);
        check("gen_level", 8'(bus.level), 8'd1);
        check("gen_on", 8'(bus.disp_on), 8'd0);
        cyc();
        check("show_on", 8'(bus.disp_on), 8'd1);
        check("show_digit", 8'(bus.disp_digit), 8'd7);

        // Start while busy is ignored
        bus.rnd   = 4'd5;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("busy_start_level", 8'(bus.level), 8'd1);
        check("busy_start_digit", 8'(bus.disp_digit), 8'd7);
        check("busy_start_on", 8'(bus.disp_on), 8'd1);

        // Reset beats start and key in the middle of a game
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd7;
        bus.tick      = 1'b1;
        cyc();
        check_idle("abort");
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        bus.tick      = 1'b0;
        cyc();
        check_idle("abort_hold");

        // Full three-level game 3 / 3,9 / 3,9,1 ending in a win
        exp_q.push_back(4'd3);
        start_game(4'd3);
        play_level(1);
        bus.rnd = 4'd9;
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd9);
        key(4'd3);
        cyc();
        check("lvl2_level", 8'(bus.level), 8'd2);
        play_level(2);
        key(4'd3);
        bus.rnd = 4'd1;
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd1);
        key(4'd9);
        cyc();
        check("lvl3_level", 8'(bus.level), 8'd3);
        play_level(3);
        key(4'd3);
        key(4'd9);
        key(4'd1);
        check("win_win", 8'(bus.win), 8'd1);
        check("win_level", 8'(bus.level), 8'd3);
        check("win_busy", 8'(bus.busy), 8'd0);
        check("win_on", 8'(bus.disp_on), 8'd0);
        check("win_lose", 8'(bus.lose), 8'd0);

        // Wrong second key on level 2 (sequence 4,6)
        exp_q.push_back(4'd4);
        start_game(4'd4);
        check("restart_win_cleared", 8'(bus.win), 8'd0);
        play_level(1);
        bus.rnd = 4'd6;
        exp_q.push_back(4'd4);
        exp_q.push_back(4'd6);
        key(4'd4);
        cyc();
        play_level(2);
        key(4'd4);
        key(4'd5);
        check("mismatch_lose", 8'(bus.lose), 8'd1);
        check("mismatch_digit", 8'(bus.disp_digit), 8'd6);
        check("mismatch_on", 8'(bus.disp_on), 8'd1);
        check("mismatch_level", 8'(bus.level), 8'd2);
        check("mismatch_busy", 8'(bus.busy), 8'd0);

        // rnd=12 folds to 2; keys outside INPUT ignored; timeout behaviour
        exp_q.push_back(4'd2);
        start_game(4'd12);
        check("restart_lose_cleared", 8'(bus.lose), 8'd0);
        key(4'd9);
        check("show_key_ignored_busy", 8'(bus.busy), 8'd1);
        check("show_key_ignored_lose", 8'(bus.lose), 8'd0);
        play_level(1);
        bus.rnd = 4'd5;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd5);
        key(4'd2);
        cyc();
        play_level(2);
        repeat (15) tick_pulse();
        check("to15_lose", 8'(bus.lose), 8'd0);
        bus.tick      = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_digit = 4'd2;
        cyc();
        bus.tick      = 1'b0;
        bus.key_valid = 1'b0;
        check("key_on_timeout_lose", 8'(bus.lose), 8'd0);
        check("key_on_timeout_busy", 8'(bus.busy), 8'd1);
        repeat (15) tick_pulse();
        check("to15b_lose", 8'(bus.lose), 8'd0);
        tick_pulse();
        check("timeout_lose", 8'(bus.lose), 8'd1);
        check("timeout_digit", 8'(bus.disp_digit), 8'd5);
        check("timeout_on", 8'(bus.disp_on), 8'd1);
        check("timeout_level", 8'(bus.level), 8'd2);
        check("timeout_busy", 8'(bus.busy), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
